register_alias_table: RTL and testbench

//  Register Alias Table (RAT) for the rename stage of the out-of-order core.

---
 rtl/rat_pkg.sv | 15 +
 rtl/rat_free_list.sv | 44 ++++
 rtl/register_alias_table.sv | 100 ++++++++++
 tb/tb_register_alias_table.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared sizing and types for the register alias table.
//   NUM_ARCH_REGS / NUM_PHYS_REGS : default table sizes
//   ARCH_REG_WIDTH / PHYS_REG_WIDTH : index widths derived from the sizes
//   arch_reg_t / phys_reg_t : register index types at the default sizes
package rat_pkg;

  localparam int unsigned NUM_ARCH_REGS  = 8;
  localparam int unsigned NUM_PHYS_REGS  = 16;
  localparam int unsigned ARCH_REG_WIDTH = $clog2(NUM_ARCH_REGS);
  localparam int unsigned PHYS_REG_WIDTH = $clog2(NUM_PHYS_REGS);

  typedef logic [ARCH_REG_WIDTH-1:0] arch_reg_t;
  typedef logic [PHYS_REG_WIDTH-1:0] phys_reg_t;

endpackage

// File: rtl/rat_free_list.sv
// Physical register free list with a lowest-index allocator.
// Registers are only ever taken; the whole pool returns to free on reset.
//   clk          : clock
//   rst          : synchronous active-high reset, frees every register
//   alloc_en     : consume the current candidate at the next edge
//   alloc_valid  : at least one register is free
//   alloc_idx    : lowest-indexed free register (0 when none is free)
module rat_free_list
  import rat_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_PHYS_REGS,
  localparam int unsigned IDX_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en,
  output logic                 alloc_valid,
  output logic [IDX_WIDTH-1:0] alloc_idx
);

  logic [NUM_REGS-1:0] phys_free;

  // Priority encoder: scan high to low so the lowest free index wins.
  always_comb begin
    alloc_valid = 1'b0;
    alloc_idx   = '0;
    for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
      if (phys_free[i]) begin
        alloc_valid = 1'b1;
        alloc_idx   = IDX_WIDTH'(i);
      end
    end
  end

  // Reset takes priority, so an allocation in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      phys_free <= '1;
    end else if (alloc_en && alloc_valid) begin
      phys_free[alloc_idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/register_alias_table.sv
// Register alias table for the rename stage.
// Two zero-latency source lookups and one rename port per cycle; the table
// updates at the clock edge, so lookups always see the pre-edge mapping.
//   clk, rst                         : clock, synchronous active-high reset
//   arch_reg_dest_in, rename_in_valid: rename request
//   rename_out_valid, phys_reg_dest_out : grant and newly allocated register
//   arch_reg_srcN_in, readN_in_valid : source lookup request (N = 1, 2)
//   readN_out_valid, readN_found, phys_reg_srcN_out : lookup result
// All outputs are combinational and held at 0 while rst is asserted.
module register_alias_table
  import rat_pkg::*;
#(
  parameter int unsigned NUM_ARCH  = NUM_ARCH_REGS,
  parameter int unsigned NUM_PHYS  = NUM_PHYS_REGS,
  localparam int unsigned ARCH_W   = $clog2(NUM_ARCH),
  localparam int unsigned PHYS_W   = $clog2(NUM_PHYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ARCH_W-1:0] arch_reg_dest_in,
  input  logic              rename_in_valid,
  output logic              rename_out_valid,
  output logic [PHYS_W-1:0] phys_reg_dest_out,
  input  logic [ARCH_W-1:0] arch_reg_src1_in,
  input  logic              read1_in_valid,
  output logic              read1_out_valid,
  output logic [PHYS_W-1:0] phys_reg_src1_out,
  output logic              read1_found,
  input  logic [ARCH_W-1:0] arch_reg_src2_in,
  input  logic              read2_in_valid,
  output logic              read2_out_valid,
  output logic [PHYS_W-1:0] phys_reg_src2_out,
  output logic              read2_found
);

  logic [PHYS_W-1:0]   map [NUM_ARCH];
  logic [NUM_ARCH-1:0] map_valid;

  logic              alloc_valid;
  logic [PHYS_W-1:0] alloc_idx;
  logic              grant;

  // A grant needs a request and a free register; reset overrides it.
  assign grant = rename_in_valid && alloc_valid && !rst;

  rat_free_list #(
    .NUM_REGS (NUM_PHYS)
  ) u_free_list (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (grant),
    .alloc_valid (alloc_valid),
    .alloc_idx   (alloc_idx)
  );

  // Mapping table: the old mapping of dest is simply overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      map_valid <= '0;
      for (int i = 0; i < int'(NUM_ARCH); i++) begin
        map[i] <= '0;
      end
    end else if (grant) begin
      map[arch_reg_dest_in]       <= alloc_idx;
      map_valid[arch_reg_dest_in] <= 1'b1;
    end
  end

  // Rename response.
  always_comb begin
    rename_out_valid  = grant;
    phys_reg_dest_out = '0;
    if (grant) begin
      phys_reg_dest_out = alloc_idx;
    end
  end

  // Source lookups read the pre-edge table, independent of the rename port.
  always_comb begin
    read1_out_valid   = 1'b0;
    read1_found       = 1'b0;
    phys_reg_src1_out = '0;
    read2_out_valid   = 1'b0;
    read2_found       = 1'b0;
    phys_reg_src2_out = '0;
    if (!rst) begin
      read1_out_valid = read1_in_valid;
      read1_found     = read1_in_valid && map_valid[arch_reg_src1_in];
      if (read1_found) begin
        phys_reg_src1_out = map[arch_reg_src1_in];
      end
      read2_out_valid = read2_in_valid;
      read2_found     = read2_in_valid && map_valid[arch_reg_src2_in];
      if (read2_found) begin
        phys_reg_src2_out = map[arch_reg_src2_in];
      end
    end
  end

endmodule

// File: tb/tb_register_alias_table.sv
// Randomized and directed bench for register_alias_table with a
// queue-based scoreboard and a behavioural rename model.
module tb_register_alias_table;

  localparam int NA = 8;
  localparam int NP = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] arch_reg_dest_in;
  logic       rename_in_valid;
  logic       rename_out_valid;
  logic [3:0] phys_reg_dest_out;
  logic [2:0] arch_reg_src1_in;
  logic       read1_in_valid;
  logic       read1_out_valid;
  logic [3:0] phys_reg_src1_out;
  logic       read1_found;
  logic [2:0] arch_reg_src2_in;
  logic       read2_in_valid;
  logic       read2_out_valid;
  logic [3:0] phys_reg_src2_out;
  logic       read2_found;

  always #5 clk = ~clk;

  register_alias_table dut (
    .clk               (clk),
    .rst               (rst),
    .arch_reg_dest_in  (arch_reg_dest_in),
    .rename_in_valid   (rename_in_valid),
    .rename_out_valid  (rename_out_valid),
    .phys_reg_dest_out (phys_reg_dest_out),
    .arch_reg_src1_in  (arch_reg_src1_in),
    .read1_in_valid    (read1_in_valid),
    .read1_out_valid   (read1_out_valid),
    .phys_reg_src1_out (phys_reg_src1_out),
    .read1_found       (read1_found),
    .arch_reg_src2_in  (arch_reg_src2_in),
    .read2_in_valid    (read2_in_valid),
    .read2_out_valid   (read2_out_valid),
    .phys_reg_src2_out (phys_reg_src2_out),
    .read2_found       (read2_found)
  );

  typedef struct {
    string tag;
    int    rv;
    int    dest;
    int    r1v;
    int    f1;
    int    p1;
    int    r2v;
    int    f2;
    int    p2;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: arch reg -> phys reg, plus a count of registers handed out.
  // Since nothing is ever freed, allocation is strictly sequential from T0.
  int m_map  [NA];
  bit m_valid[NA];
  int m_used;

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_map[i]   = 0;
      m_valid[i] = 0;
    end
    m_used = 0;
  endtask

  task automatic chk(input string tag, input string field, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0d expected=%0d", tag, field, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, "rename_out_valid",  int'(rename_out_valid),  e.rv);
      chk(e.tag, "phys_reg_dest_out", int'(phys_reg_dest_out), e.dest);
      chk(e.tag, "read1_out_valid",   int'(read1_out_valid),   e.r1v);
      chk(e.tag, "read1_found",       int'(read1_found),       e.f1);
      chk(e.tag, "phys_reg_src1_out", int'(phys_reg_src1_out), e.p1);
      chk(e.tag, "read2_out_valid",   int'(read2_out_valid),   e.r2v);
      chk(e.tag, "read2_found",       int'(read2_found),       e.f2);
      chk(e.tag, "phys_reg_src2_out", int'(phys_reg_src2_out), e.p2);
    end
  end

  // Drive one cycle of stimulus, push its expected response, then advance the model.
  task automatic cycle(input string tag, input bit r, input bit ren, input int d,
                       input bit v1, input int s1, input bit v2, input int s2);
    exp_t e;
    rst              = r;
    rename_in_valid  = ren;
    arch_reg_dest_in = 3'(d);
    read1_in_valid   = v1;
    arch_reg_src1_in = 3'(s1);
    read2_in_valid   = v2;
    arch_reg_src2_in = 3'(s2);

    e.tag = tag;
    if (r) begin
      e.rv = 0; e.dest = 0; e.r1v = 0; e.f1 = 0; e.p1 = 0; e.r2v = 0; e.f2 = 0; e.p2 = 0;
    end else begin
      e.rv   = (ren && m_used < NP) ? 1 : 0;
      e.dest = e.rv ? m_used : 0;
      e.r1v  = v1 ? 1 : 0;
      e.f1   = (v1 && m_valid[s1]) ? 1 : 0;
      e.p1   = e.f1 ? m_map[s1] : 0;
      e.r2v  = v2 ? 1 : 0;
      e.f2   = (v2 && m_valid[s2]) ? 1 : 0;
      e.p2   = e.f2 ? m_map[s2] : 0;
    end
    exp_q.push_back(e);

    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (ren && m_used < NP) begin
      m_map[d]   = m_used;
      m_valid[d] = 1;
      m_used++;
    end
    #1;
  endtask

  initial begin
    int wait_cycles;
    rst = 1'b1; rename_in_valid = 1'b0; arch_reg_dest_in = '0;
    read1_in_valid = 1'b0; arch_reg_src1_in = '0;
    read2_in_valid = 1'b0; arch_reg_src2_in = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset with requests present: every output must stay at 0.
    cycle("reset0", 1, 1, 1, 1, 1, 1, 1);
    cycle("reset1", 1, 0, 0, 0, 0, 0, 0);

    // First rename, reads of unmapped regs.
    cycle("t1_first", 0, 1, 1, 1, 2, 1, 3);
    // Both ports on the same reg; next allocation.
    cycle("t2_same", 0, 1, 4, 1, 1, 1, 1);
    // ADD R1,R1,R1: old mapping read, then new mapping visible.
    cycle("t3_add", 0, 1, 1, 1, 1, 1, 1);
    cycle("t3_after", 0, 0, 0, 1, 1, 1, 4);

    // Exhaustion: 16 grants from reset, 17th rejected, table untouched.
    cycle("t4_rst", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NP; i++) cycle("t4_fill", 0, 1, i % NA, 1, i % NA, 0, 0);
    cycle("t4_17th", 0, 1, 3, 1, 3, 1, 7);
    cycle("t4_check", 0, 1, 3, 1, 3, 1, 0);

    // Reset beats a simultaneous rename; then R5 gets T0 and older maps are gone.
    cycle("t5_rst", 1, 1, 2, 1, 2, 0, 0);
    cycle("t5_ren", 0, 1, 5, 1, 5, 1, 7);
    cycle("t5_read", 0, 0, 0, 1, 5, 1, 1);

    // Disabled read port on a mapped register.
    cycle("t6_map", 0, 1, 1, 0, 0, 0, 0);
    cycle("t6_off", 0, 0, 0, 0, 1, 1, 1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      cycle("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, NA - 1)),
            ($urandom_range(0, 3) != 0), int'($urandom_range(0, NA - 1)),
            ($urandom_range(0, 3) != 0), int'($urandom_range(0, NA - 1)));
    end

    rename_in_valid = 1'b0; read1_in_valid = 1'b0; read2_in_valid = 1'b0;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
